// File: rtl/paddle_mux_if.sv
// paddle_mux_if: host-side controller inputs (hps_io) and console-side paddle outputs.
// master drives the controller inputs; slave is the paddle_mux itself.
interface paddle_mux_if #(
  parameter int NCH = 4
);
  localparam int MCW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              inv;
  logic [MCW-1:0]    mouse_ch;
  logic [NCH-1:0]    stick_btn;
  logic [16*NCH-1:0] joy_a;
  logic [NCH-1:0]    paddle_btn;
  logic [8*NCH-1:0]  paddle;
  logic [24:0]       ps2_mouse;
  logic [8*NCH-1:0]  a_out;
  logic [NCH-1:0]    b_out;
  logic [2*NCH-1:0]  src;

  modport master (
    output inv, mouse_ch, stick_btn, joy_a, paddle_btn, paddle, ps2_mouse,
    input  a_out, b_out, src
  );

  modport slave (
    input  inv, mouse_ch, stick_btn, joy_a, paddle_btn, paddle, ps2_mouse,
    output a_out, b_out, src
  );
endinterface

// File: rtl/paddle_mux.sv
// paddle_mux: N-channel paddle/stick/mouse mapper producing pot values and fire buttons.
// Optional output slew limiting is enabled with the PADDLE_SLEW_EN macro.
module paddle_mux #(
  parameter int NCH          = 4,
  parameter int STICK_THRESH = 100,
  parameter int MOUSE_CLAMP  = 10,
  parameter int SLEW_DIV     = 256,
  parameter int SLEW_STEP    = 4
) (
  input logic         clk,
  input logic         reset_n,
  paddle_mux_if.slave bus
);

  localparam int MCW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic signed [7:0] THRESH8 = 8'(STICK_THRESH);
  localparam logic signed [8:0] CLAMP9  = 9'(MOUSE_CLAMP);
  localparam logic signed [8:0] NCLAMP9 = -CLAMP9;

  typedef enum logic [1:0] {
    SRC_PADDLE = 2'd0,
    SRC_STICK  = 2'd1,
    SRC_MOUSE  = 2'd2
  } src_e;

  // Half-resolution mouse delta, limited so one fast packet cannot jump the pot.
  function automatic logic signed [7:0] mouse_delta(input logic sgn, input logic [7:0] mag);
    logic signed [8:0] raw;
    raw = $signed({sgn, mag}) >>> 1;
    if (raw > CLAMP9)       return CLAMP9[7:0];
    else if (raw < NCLAMP9) return NCLAMP9[7:0];
    else                    return raw[7:0];
  endfunction

  function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                input logic signed [7:0] b);
    logic [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    else              return s[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Mouse strobe detection. The history is captured on the first clk after
  // reset release, so a strobe already high at release is not seen as a packet.
  // ---------------------------------------------------------------------------
  logic strobe_q;
  logic primed_q;
  logic pkt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      strobe_q <= bus.ps2_mouse[24];
      primed_q <= 1'b1;
    end
  end

  assign pkt = primed_q && (bus.ps2_mouse[24] != strobe_q);

  logic signed [7:0] dx;
  logic signed [7:0] dy;

  assign dx = mouse_delta(bus.ps2_mouse[4], bus.ps2_mouse[15:8]);
  assign dy = mouse_delta(bus.ps2_mouse[5], bus.ps2_mouse[23:16]);

  logic unused_mouse_bits;
  assign unused_mouse_bits = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};

  // ---------------------------------------------------------------------------
  // Per-channel source FSM
  // ---------------------------------------------------------------------------
  src_e           src_q [NCH];
  src_e           src_d [NCH];
  logic [NCH-1:0] pkt_ch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) src_q[i] <= SRC_PADDLE;
    end else begin
      for (int i = 0; i < NCH; i++) src_q[i] <= src_d[i];
    end
  end

  // NOTE: every always_comb output is given a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pkt_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      src_d[i]  = src_q[i];
      pkt_ch[i] = pkt && (bus.mouse_ch == MCW'(i));
      if (bus.paddle_btn[i])     src_d[i] = SRC_PADDLE;
      else if (bus.stick_btn[i]) src_d[i] = SRC_STICK;
      else if (pkt_ch[i])        src_d[i] = SRC_MOUSE;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel datapath: mouse accumulators, axis select, target and fire
  // ---------------------------------------------------------------------------
  logic              xy_q [NCH];
  logic              xy_d [NCH];
  logic signed [7:0] mx_q [NCH];
  logic signed [7:0] my_q [NCH];
  logic signed [7:0] mx_d [NCH];
  logic signed [7:0] my_d [NCH];
  logic [7:0]        t_q  [NCH];
  logic [7:0]        t_d  [NCH];
  logic [NCH-1:0]    fire_d;
  logic [NCH-1:0]    b_q;

  always_comb begin
    logic signed [7:0] joy_x;
    logic signed [7:0] joy_y;
    logic [7:0]        pad;
    logic [7:0]        tv;

    fire_d = '0;
    for (int i = 0; i < NCH; i++) begin
      joy_x = $signed(bus.joy_a[16*i +: 8]);
      joy_y = $signed(bus.joy_a[16*i+8 +: 8]);
      pad   = bus.paddle[8*i +: 8];

      // Accumulators follow their channel's packets even while another source is active.
      mx_d[i] = mx_q[i];
      my_d[i] = my_q[i];
      if (pkt_ch[i]) begin
        mx_d[i] = sat_add(mx_q[i], dx);
        my_d[i] = sat_add(my_q[i], dy);
      end

      xy_d[i] = xy_q[i];
      case (src_q[i])
        SRC_MOUSE: begin
          if (bus.ps2_mouse[0])      xy_d[i] = 1'b0;
          else if (bus.ps2_mouse[1]) xy_d[i] = 1'b1;
        end
        SRC_STICK: begin
          if (!joy_x[7] && (joy_x > THRESH8))      xy_d[i] = 1'b0;
          else if (!joy_y[7] && (joy_y > THRESH8)) xy_d[i] = 1'b1;
        end
        default: ;
      endcase

      case (src_q[i])
        SRC_STICK: begin
          tv        = xy_d[i] ? joy_y : joy_x;
          fire_d[i] = bus.stick_btn[i];
        end
        SRC_MOUSE: begin
          tv        = xy_d[i] ? my_d[i] : mx_d[i];
          fire_d[i] = |bus.ps2_mouse[1:0];
        end
        default: begin
          tv        = {~pad[7], pad[6:0]};
          fire_d[i] = bus.paddle_btn[i];
        end
      endcase

      t_d[i] = tv ^ {8{bus.inv}};
    end
  end

  // NOTE: the small per-channel register arrays are reset element by element;
  // they are flops with defined power-up values, not a RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        xy_q[i] <= 1'b0;
        mx_q[i] <= '0;
        my_q[i] <= '0;
        t_q[i]  <= '0;
      end
      b_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        xy_q[i] <= xy_d[i];
        mx_q[i] <= mx_d[i];
        my_q[i] <= my_d[i];
        t_q[i]  <= t_d[i];
      end
      b_q <= fire_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [7:0] a_q [NCH];

`ifdef PADDLE_SLEW_EN
  localparam int         CW    = (SLEW_DIV > 2) ? $clog2(SLEW_DIV) : 1;
  localparam logic [7:0] STEP8 = 8'(SLEW_STEP);

  logic [CW-1:0] slew_cnt;
  logic          slew_step;
  src_e          t_src_q [NCH];
  src_e          a_src_q [NCH];

  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (tgt > cur) return ((tgt - cur) > STEP8) ? cur + STEP8 : tgt;
    else           return ((cur - tgt) > STEP8) ? cur - STEP8 : tgt;
  endfunction

  assign slew_step = (slew_cnt == CW'(SLEW_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       slew_cnt <= '0;
    else if (slew_step) slew_cnt <= '0;
    else                slew_cnt <= slew_cnt + 1'b1;
  end

  // t_src_q tags t_q with the source it was built from; a mismatch with the
  // source a_out last tracked means a source switch, which snaps immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        t_src_q[i] <= SRC_PADDLE;
        a_src_q[i] <= SRC_PADDLE;
        a_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        t_src_q[i] <= src_q[i];
        a_src_q[i] <= t_src_q[i];
        if (t_src_q[i] != a_src_q[i]) a_q[i] <= t_q[i];
        else if (slew_step)           a_q[i] <= slew_toward(a_q[i], t_q[i]);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) a_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) a_q[i] <= t_q[i];
    end
  end
`endif

  always_comb begin
    bus.a_out = '0;
    bus.src   = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.a_out[8*i +: 8] = a_q[i];
      bus.src[2*i +: 2]   = src_q[i];
    end
  end

  assign bus.b_out = b_q;

endmodule

// File: tb/tb_paddle_mux.sv
// tb_paddle_mux: directed-vector bench for paddle_mux (default build, NCH=4).
module tb_paddle_mux;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic tog = 1'b0;
  int   checks = 0;
  int   errors = 0;

  paddle_mux_if #(.NCH(NCH)) bus ();

  paddle_mux #(.NCH(NCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] x, input logic xs,
                          input logic [7:0] y, input logic ys, input logic [1:0] btn);
    tog = ~tog;
    bus.ps2_mouse = {tog, y, x, 2'b00, ys, xs, 2'b00, btn};
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.inv        = 1'b0;
    bus.mouse_ch   = '0;
    bus.stick_btn  = '0;
    bus.joy_a      = '0;
    bus.paddle_btn = '0;
    bus.paddle     = '0;
    bus.ps2_mouse  = '0;
    #3;
    checks++;
    if (bus.a_out !== 32'h0) begin errors++; $display("FAIL reset_a_out got %h want %h", bus.a_out, 32'h0); end
    checks++;
    if (bus.b_out !== 4'h0) begin errors++; $display("FAIL reset_b_out got %b want %b", bus.b_out, 4'h0); end
    checks++;
    if (bus.src !== 8'h0) begin errors++; $display("FAIL reset_src got %h want %h", bus.src, 8'h0); end
    tick(2);
    reset_n = 1'b1;
    tick(3);
    checks++;
    if (bus.a_out !== 32'h80808080) begin errors++; $display("FAIL idle_a_out got %h want %h", bus.a_out, 32'h80808080); end
  endtask

  task automatic test_paddle();
    bus.paddle[7:0] = 8'h10;
    tick(1);
    checks++;
    if (bus.a_out[7:0] !== 8'h80) begin errors++; $display("FAIL paddle_latency1 got %h want %h", bus.a_out[7:0], 8'h80); end
    tick(1);
    checks++;
    if (bus.a_out[7:0] !== 8'h90) begin errors++; $display("FAIL paddle_value got %h want %h", bus.a_out[7:0], 8'h90); end
    checks++;
    if (bus.src[1:0] !== 2'd0) begin errors++; $display("FAIL paddle_src got %0d want 0", bus.src[1:0]); end
    bus.inv = 1'b1;
    tick(2);
    checks++;
    if (bus.a_out !== 32'h7F7F7F6F) begin errors++; $display("FAIL paddle_inv got %h want %h", bus.a_out, 32'h7F7F7F6F); end
    bus.inv = 1'b0;
    bus.paddle_btn[0] = 1'b1;
    tick(1);
    checks++;
    if (bus.b_out !== 4'b0001) begin errors++; $display("FAIL paddle_fire got %b want %b", bus.b_out, 4'b0001); end
    bus.paddle_btn[0] = 1'b0;
    tick(2);
  endtask

  task automatic test_mouse();
    bus.mouse_ch = 2'd1;
    send_pkt(8'd40, 1'b0, 8'd0, 1'b0, 2'b00);
    tick(1);
    checks++;
    if (bus.src !== 8'h08) begin errors++; $display("FAIL mouse_src got %h want %h", bus.src, 8'h08); end
    tick(2);
    checks++;
    if (bus.a_out[15:8] !== 8'h0A) begin errors++; $display("FAIL mouse_clamp got %h want %h", bus.a_out[15:8], 8'h0A); end
    for (int k = 0; k < 12; k++) begin
      send_pkt(8'd40, 1'b0, 8'd0, 1'b0, 2'b00);
      tick(1);
    end
    tick(2);
    checks++;
    if (bus.a_out[15:8] !== 8'h7F) begin errors++; $display("FAIL mouse_saturate got %h want %h", bus.a_out[15:8], 8'h7F); end
    send_pkt(8'hC0, 1'b1, 8'd0, 1'b0, 2'b00);
    tick(2);
    checks++;
    if (bus.a_out[15:8] !== 8'h75) begin errors++; $display("FAIL mouse_negative got %h want %h", bus.a_out[15:8], 8'h75); end
    send_pkt(8'd0, 1'b0, 8'd6, 1'b0, 2'b10);
    tick(1);
    checks++;
    if (bus.b_out !== 4'b0010) begin errors++; $display("FAIL mouse_fire got %b want %b", bus.b_out, 4'b0010); end
    tick(1);
    checks++;
    if (bus.a_out[15:8] !== 8'h03) begin errors++; $display("FAIL mouse_y_axis got %h want %h", bus.a_out[15:8], 8'h03); end
    bus.ps2_mouse[1:0] = 2'b00;
    tick(2);
    checks++;
    if (bus.b_out !== 4'b0000) begin errors++; $display("FAIL mouse_fire_release got %b want %b", bus.b_out, 4'b0000); end
    checks++;
    if (bus.a_out[15:8] !== 8'h03) begin errors++; $display("FAIL mouse_xy_hold got %h want %h", bus.a_out[15:8], 8'h03); end
    bus.mouse_ch = 2'd3;
    send_pkt(8'd4, 1'b0, 8'd0, 1'b0, 2'b00);
    tick(1);
    checks++;
    if (bus.src !== 8'h88) begin errors++; $display("FAIL mouse_ch_switch_src got %h want %h", bus.src, 8'h88); end
    tick(2);
    checks++;
    if (bus.a_out[31:8] !== {8'h02, 8'h80, 8'h03}) begin
      errors++; $display("FAIL mouse_ch_switch_a got %h want %h", bus.a_out[31:8], {8'h02, 8'h80, 8'h03});
    end
  endtask

  task automatic test_priority();
    bus.stick_btn[2]  = 1'b1;
    bus.paddle_btn[2] = 1'b1;
    tick(1);
    checks++;
    if (bus.src[5:4] !== 2'd0) begin errors++; $display("FAIL prio_src got %0d want 0", bus.src[5:4]); end
    checks++;
    if (bus.b_out !== 4'b0100) begin errors++; $display("FAIL prio_fire got %b want %b", bus.b_out, 4'b0100); end
    bus.paddle_btn[2] = 1'b0;
    tick(1);
    checks++;
    if (bus.src[5:4] !== 2'd1) begin errors++; $display("FAIL prio_stick_src got %0d want 1", bus.src[5:4]); end
    tick(1);
    checks++;
    if (bus.b_out !== 4'b0100) begin errors++; $display("FAIL prio_stick_fire got %b want %b", bus.b_out, 4'b0100); end
    bus.stick_btn[2] = 1'b0;
    tick(1);
    checks++;
    if (bus.b_out !== 4'b0000) begin errors++; $display("FAIL prio_fire_release got %b want %b", bus.b_out, 4'b0000); end
    checks++;
    if (bus.src[5:4] !== 2'd1) begin errors++; $display("FAIL prio_hold got %0d want 1", bus.src[5:4]); end
  endtask

  task automatic test_stick();
    bus.joy_a[15:0]  = {8'd110, 8'd0};
    bus.stick_btn[0] = 1'b1;
    tick(1);
    bus.stick_btn[0] = 1'b0;
    tick(2);
    checks++;
    if (bus.a_out[7:0] !== 8'd110) begin errors++; $display("FAIL stick_y got %0d want %0d", bus.a_out[7:0], 110); end
    bus.joy_a[15:0] = {8'd110, 8'd101};
    tick(2);
    checks++;
    if (bus.a_out[7:0] !== 8'd101) begin errors++; $display("FAIL stick_x_wins got %0d want %0d", bus.a_out[7:0], 101); end
    bus.joy_a[15:0] = {8'd110, 8'd100};
    tick(2);
    checks++;
    if (bus.a_out[7:0] !== 8'd110) begin errors++; $display("FAIL stick_thresh_edge got %0d want %0d", bus.a_out[7:0], 110); end
    bus.joy_a[15:0] = {8'd20, 8'hF0};
    tick(2);
    checks++;
    if (bus.a_out[7:0] !== 8'd20) begin errors++; $display("FAIL stick_neg_hold got %0d want %0d", bus.a_out[7:0], 20); end
  endtask

  task automatic test_async_reset();
    bus.paddle   = '0;
    bus.joy_a    = '0;
    bus.mouse_ch = 2'd1;
    send_pkt(8'd40, 1'b0, 8'd40, 1'b0, 2'b01);
    tick(3);
    checks++;
    if (bus.b_out !== 4'b1010) begin errors++; $display("FAIL areset_pre_fire got %b want %b", bus.b_out, 4'b1010); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.a_out !== 32'h0) begin errors++; $display("FAIL areset_a_out got %h want %h", bus.a_out, 32'h0); end
    checks++;
    if (bus.b_out !== 4'h0) begin errors++; $display("FAIL areset_b_out got %b want %b", bus.b_out, 4'h0); end
    checks++;
    if (bus.src !== 8'h0) begin errors++; $display("FAIL areset_src got %h want %h", bus.src, 8'h0); end
    tick(1);
    reset_n = 1'b1;
    tick(1);
    checks++;
    if (bus.src !== 8'h0) begin errors++; $display("FAIL areset_no_spurious got %h want %h", bus.src, 8'h0); end
    send_pkt(8'd40, 1'b0, 8'd0, 1'b0, 2'b00);
    tick(1);
    checks++;
    if (bus.src !== 8'h08) begin errors++; $display("FAIL areset_mouse_src got %h want %h", bus.src, 8'h08); end
    tick(2);
    checks++;
    if (bus.a_out[15:8] !== 8'h0A) begin errors++; $display("FAIL areset_acc_cleared got %h want %h", bus.a_out[15:8], 8'h0A); end
  endtask

  initial begin
    test_reset();
    test_paddle();
    test_mouse();
    test_priority();
    test_stick();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
